load_writeback: RTL
===================

# load_writeback

Drives the write port of the CPU register file. Merges single-cycle ALU results with multi-cycle memory loads that arrive one byte at a time from the serial memory interface. Loads are assembled little-endian, sign- or zero-extended per funct3, and presented as a registered one-cycle write of `write_register`/`write_value`.

## Interface
Parameters:
- none.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ld_start`  in  1  one-cycle pulse that begins a load; sampled only in IDLE.
- `ld_rd`  in  4  destination register; captured with `ld_start`.
- `ld_funct3`  in  3  load type; captured with `ld_start`.
- `byte_valid`  in  1  memory byte available.
- `byte_data`  in  8  memory byte.
- `byte_ready`  out  1  unit accepts a byte; transfer when `byte_valid && byte_ready`.
- `alu_we`  in  1  ALU write request.
- `alu_rd`  in  4  ALU destination.
- `alu_value`  in  32  ALU result.
- `alu_ready`  out  1  ALU request accepted this cycle.
- `flush`  in  1  synchronous abort of an in-progress load.
- `busy`  out  1  high in RECV.
- `ld_done`  out  1  one-cycle pulse, coincident with the load's write.
- `write_register`  out  4  register-file write select; 0 means no write.
- `write_value`  out  32  register-file write data.

## Operation
- FSM states are IDLE and RECV.
- IDLE: `ld_start` captures `ld_rd` and `ld_funct3`, clears the byte counter and goes to RECV. `ld_start` in RECV is ignored.
- RECV: `byte_ready`=1. Each accepted byte k (k=0..3) is stored into bits [8k+7:8k].
- Bytes needed: LB (000) and LBU (100) need 1; LH (001) and LHU (101) need 2; LW (010) needs 4. Codes 011, 110 and 111 are treated as LW.
- Last byte accepted: state returns to IDLE. On the next edge, `write_register`=rd, `write_value`=the extended result, and `ld_done`=1.
- Extension: LB and LH sign-extend from bit 7 and bit 15. LBU and LHU zero-extend.
- Load to rd=0: bytes are still consumed and `ld_done` pulses, but `write_register`=0.
- ALU path: when `alu_we && alu_ready`, the next edge drives `write_register`=alu_rd and `write_value`=alu_value. This is allowed in both IDLE and RECV.
- Collision: `alu_ready` = !(RECV && byte_valid && last byte). On a collision the load wins and the ALU must hold its request.
- Idle output: with no write, `write_register`=0 and `write_value`=0.
- Flush: in RECV, `flush` returns to IDLE and discards collected bytes. No write and no `ld_done` are produced. `flush` has priority over a byte transfer in the same cycle. In IDLE, `flush` has no effect.

## Timing
- Reset values: state IDLE, counter 0, `byte_ready`=0, `busy`=0, `ld_done`=0, `write_register`=0, `write_value`=0, `alu_ready`=1.
- Reset asserted mid-load abandons the load. No write occurs.
- `byte_ready`, `busy` and `alu_ready` are combinational from state and inputs. `write_register`, `write_value` and `ld_done` are registered.
- Load latency: `ld_start` at edge 0, then first byte at edge 1 at the earliest. For LW with back-to-back bytes, the last byte lands at edge 4 and the write is visible for the cycle after edge 4.
- An ALU write is visible one cycle after acceptance.
- Every write lasts exactly one cycle.

## Configuration
- `WB_BYTE_HALF_EN` defined: LB, LH, LBU and LHU are supported as specified above.
- `WB_BYTE_HALF_EN` undefined:
  - `ld_funct3` is ignored.
  - Every load takes 4 bytes and writes the raw word.
  - The extension logic is removed.

## Structure
- Shared package `rv_pkg` holds:
  - funct3 constants `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`;
  - state encoding `WB_IDLE` and `WB_RECV`;
  - register-select width `REG_SEL_W`=4.
- One combinational sub-module, `load_extend`, maps (raw word, funct3) to the 32-bit result. It is instantiated only under `WB_BYTE_HALF_EN`.

## Test plan
- LW, rd=5, bytes 0x78,0x56,0x34,0x12 back-to-back → one-cycle write r5=0x12345678 with `ld_done`=1, then `write_register`=0.
- LB rd=3 byte 0x80 → r3=0xFFFFFF80. LBU → 0x00000080. LH bytes 0x34,0x92 → 0xFFFF9234. LHU → 0x00009234.
- ALU write rd=7 value 0xDEADBEEF during RECV with `byte_valid` low → accepted, r7 written next cycle, and the load continues unaffected.
- ALU request coinciding with the last load byte → `alu_ready`=0. The load write occurs, then the held ALU write occurs on the following cycle.
- `flush` after 2 of 4 LW bytes, and separately `rst_n` low mid-load → no write, no `ld_done`, back in IDLE. A new LW then completes correctly.
- Load to rd=0 with 4 bytes → bytes consumed, `ld_done` pulses, `write_register` stays 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the load/writeback slice: funct3 load codes,
// writeback FSM state encoding and the register-select width.
// Optional feature macro used by this slice: WB_BYTE_HALF_EN.
package rv_pkg;

  localparam int REG_SEL_W = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_RECV = 1'b1
  } wb_state_t;

  // Index of the final byte of a load; unlisted codes behave as LW.
  function automatic logic [1:0] last_byte_idx(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: last_byte_idx = 2'd0;
      F3_LH, F3_LHU: last_byte_idx = 2'd1;
      default:       last_byte_idx = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/load_writeback_if.sv
// Bundle of the load request, serial byte stream, ALU request and the
// register-file write port seen by load_writeback.
//
// Handshakes: a byte moves on a rising edge where byte_valid && byte_ready;
// an ALU write is taken on a rising edge where alu_we && alu_ready. A
// requester that sees ready low must hold valid and its payload stable
// until the transfer happens.
interface load_writeback_if;
  import rv_pkg::*;

  logic                 ld_start;
  logic [REG_SEL_W-1:0] ld_rd;
  logic [2:0]           ld_funct3;
  logic                 byte_valid;
  logic [7:0]           byte_data;
  logic                 byte_ready;
  logic                 alu_we;
  logic [REG_SEL_W-1:0] alu_rd;
  logic [31:0]          alu_value;
  logic                 alu_ready;
  logic                 flush;
  logic                 busy;
  logic                 ld_done;
  logic [REG_SEL_W-1:0] write_register;
  logic [31:0]          write_value;

  modport slave (
    input  ld_start, ld_rd, ld_funct3, byte_valid, byte_data,
           alu_we, alu_rd, alu_value, flush,
    output byte_ready, alu_ready, busy, ld_done, write_register, write_value
  );

  modport master (
    output ld_start, ld_rd, ld_funct3, byte_valid, byte_data,
           alu_we, alu_rd, alu_value, flush,
    input  byte_ready, alu_ready, busy, ld_done, write_register, write_value
  );

endinterface

// File: rtl/load_extend.sv
// Combinational load result shaping: sign/zero extension of byte and
// halfword loads from the little-endian assembled word. Only instantiated
// when WB_BYTE_HALF_EN is defined.
module load_extend
  import rv_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_value
);

  // Select the extension implied by the load type.
  always_comb begin
    o_value = i_word;
    case (i_funct3)
      F3_LB:   o_value = {{24{i_word[7]}}, i_word[7:0]};
      F3_LH:   o_value = {{16{i_word[15]}}, i_word[15:0]};
      F3_LBU:  o_value = {24'd0, i_word[7:0]};
      F3_LHU:  o_value = {16'd0, i_word[15:0]};
      default: o_value = i_word;
    endcase
  end

endmodule

// File: rtl/load_writeback.sv
// Register-file write port arbiter: merges single-cycle ALU writes with
// multi-cycle byte-serial loads. Loads win a same-cycle collision.
// Macro WB_BYTE_HALF_EN enables LB/LH/LBU/LHU; without it every load is a
// 4-byte raw word and ld_funct3 is ignored.
module load_writeback
  import rv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  load_writeback_if.slave  bus,
  output wb_state_t        o_dbg_state
);

  wb_state_t            r_state;
  wb_state_t            w_next_state;
  logic [1:0]           r_cnt;
  logic [REG_SEL_W-1:0] r_rd;
  logic [31:0]          r_data;
  logic [REG_SEL_W-1:0] r_write_register;
  logic [31:0]          r_write_value;
  logic                 r_ld_done;

  logic                 w_recv;
  logic [1:0]           w_last_idx;
  logic                 w_last;
  logic                 w_xfer;
  logic                 w_load_done;
  logic                 w_alu_fire;
  logic [31:0]          w_word;
  logic [31:0]          w_result;

`ifdef WB_BYTE_HALF_EN
  logic [2:0]           r_f3;

  assign w_last_idx = last_byte_idx(r_f3);

  load_extend u_load_extend (
    .i_word   (w_word),
    .i_funct3 (r_f3),
    .o_value  (w_result)
  );

  // Load type is captured alongside the destination at load start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_f3 <= F3_LW;
    else if (r_state == WB_IDLE && bus.ld_start) r_f3 <= bus.ld_funct3;
  end
`else
  assign w_last_idx = 2'd3;
  assign w_result   = w_word;
`endif

  assign w_recv      = (r_state == WB_RECV);
  assign w_last      = (r_cnt == w_last_idx);
  // Flush takes priority over a byte arriving in the same cycle.
  assign w_xfer      = w_recv && bus.byte_valid && !bus.flush;
  assign w_load_done = w_xfer && w_last;
  assign w_alu_fire  = bus.alu_we && bus.alu_ready;

  assign bus.byte_ready     = w_recv;
  assign bus.busy           = w_recv;
  assign bus.alu_ready      = !(w_recv && bus.byte_valid && w_last);
  assign bus.write_register = r_write_register;
  assign bus.write_value    = r_write_value;
  assign bus.ld_done        = r_ld_done;
  assign o_dbg_state        = r_state;

  // Collected bytes with the byte arriving this cycle merged in place.
  always_comb begin
    w_word = r_data;
    w_word[8*r_cnt +: 8] = bus.byte_data;
  end

  // FSM next state: IDLE waits for a start, RECV ends on last byte or flush.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      WB_IDLE: if (bus.ld_start) w_next_state = WB_RECV;
      WB_RECV: begin
        if (bus.flush)       w_next_state = WB_IDLE;
        else if (w_load_done) w_next_state = WB_IDLE;
      end
      default: w_next_state = WB_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= WB_IDLE;
    else        r_state <= w_next_state;
  end

  // Load capture: destination and cleared buffer at start, bytes as they land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 2'd0;
      r_rd   <= '0;
      r_data <= 32'd0;
    end else if (r_state == WB_IDLE && bus.ld_start) begin
      r_cnt  <= 2'd0;
      r_rd   <= bus.ld_rd;
      r_data <= 32'd0;
    end else if (w_xfer) begin
      r_cnt  <= r_cnt + 2'd1;
      r_data <= w_word;
    end
  end

  // Registered write port: one-cycle pulse from a finished load or an ALU write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write_register <= '0;
      r_write_value    <= 32'd0;
      r_ld_done        <= 1'b0;
    end else if (w_load_done) begin
      r_write_register <= r_rd;
      r_write_value    <= (r_rd == '0) ? 32'd0 : w_result;
      r_ld_done        <= 1'b1;
    end else if (w_alu_fire) begin
      r_write_register <= bus.alu_rd;
      r_write_value    <= bus.alu_value;
      r_ld_done        <= 1'b0;
    end else begin
      r_write_register <= '0;
      r_write_value    <= 32'd0;
      r_ld_done        <= 1'b0;
    end
  end

endmodule
